// File: rtl/zx_frame_gate.sv
// Frame-capture sequencer: aligns capture to ZX sync edges, crops the active window and drives DCMI strobes.
// Optional colour-bar generator is enabled by defining ZX_FRAME_GATE_PATTERN_EN.
module zx_frame_gate #(
  parameter int CNT_W   = 10,
  parameter int H_START = 64,
  parameter int H_LEN   = 256,
  parameter int V_START = 48,
  parameter int V_LEN   = 192
) (
  input  logic        ZX_PIX_CLK,
  input  logic        reset,
  input  logic [3:0]  zx_rgbi,
  input  logic        zx_hs,
  input  logic        zx_vs,
  input  logic        cfg_enable,
  input  logic        cfg_single,
  input  logic [3:0]  cfg_skip,
  input  logic        cfg_pattern,
  input  logic        arm,
  output logic [7:0]  dcmi_data,
  output logic        dcmi_vsync,
  output logic        dcmi_hsync,
  output logic        dcmi_pix_en,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE, SKIP} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W:0]   H_LO = (CNT_W+1)'(H_START);
  localparam logic [CNT_W:0]   H_HI = (CNT_W+1)'(H_START + H_LEN);
  localparam logic [CNT_W:0]   V_LO = (CNT_W+1)'(V_START);
  localparam logic [CNT_W:0]   V_HI = (CNT_W+1)'(V_START + V_LEN);

  state_t           state, state_nxt;
  logic [3:0]       skip_cnt, skip_cnt_nxt;
  logic             done_nxt;
  logic             hs_d, vs_d;
  logic             hs_rise, vs_rise;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             in_h, in_v;
  logic             line_vld;
  logic [3:0]       pix_src;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  assign hs_rise  = zx_hs & ~hs_d;
  assign vs_rise  = zx_vs & ~vs_d;
  assign in_h     = ({1'b0, h_cnt} >= H_LO) && ({1'b0, h_cnt} < H_HI);
  assign in_v     = ({1'b0, v_cnt} >= V_LO) && ({1'b0, v_cnt} < V_HI);
  assign line_vld = (state == CAPTURE) && in_v && in_h;
  assign busy     = (state != IDLE);

`ifdef ZX_FRAME_GATE_PATTERN_EN
  assign pix_src = cfg_pattern ? h_cnt[6:3] : zx_rgbi;
`else
  logic unused_cfg_pattern;
  assign unused_cfg_pattern = cfg_pattern;
  assign pix_src = zx_rgbi;
`endif

  // Config (other than cfg_enable) only matters at the transitions below.
  always_comb begin
    state_nxt    = state;
    skip_cnt_nxt = skip_cnt;
    done_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_enable && (!cfg_single || arm))
          state_nxt = WAIT_VS;
      end
      WAIT_VS: begin
        if (!cfg_enable)
          state_nxt = IDLE;
        else if (vs_rise)
          state_nxt = CAPTURE;
      end
      CAPTURE: begin
        if (vs_rise) begin
          done_nxt = 1'b1;
          if (cfg_single || !cfg_enable) begin
            state_nxt = IDLE;
          end else if (cfg_skip != 4'd0) begin
            skip_cnt_nxt = cfg_skip;
            state_nxt    = SKIP;
          end
        end
      end
      SKIP: begin
        if (!cfg_enable) begin
          state_nxt = IDLE;
        end else if (vs_rise) begin
          skip_cnt_nxt = skip_cnt - 4'd1;
          if (skip_cnt == 4'd1)
            state_nxt = CAPTURE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p1: counters, sequencer state and registered DCMI outputs
  always_ff @(posedge ZX_PIX_CLK) begin
    if (!reset) begin
      hs_d        <= 1'b0;
      vs_d        <= 1'b0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      state       <= IDLE;
      skip_cnt    <= '0;
      frame_cnt   <= '0;
      frame_done  <= 1'b0;
      dcmi_data   <= '0;
      dcmi_vsync  <= 1'b0;
      dcmi_hsync  <= 1'b0;
      dcmi_pix_en <= 1'b0;
    end else begin
      hs_d     <= zx_hs;
      vs_d     <= zx_vs;
      h_cnt    <= hs_rise ? '0 : sat_inc(h_cnt);
      if (vs_rise)
        v_cnt <= '0;
      else if (hs_rise)
        v_cnt <= sat_inc(v_cnt);
      state    <= state_nxt;
      skip_cnt <= skip_cnt_nxt;
      frame_done <= done_nxt;
      if (done_nxt)
        frame_cnt <= frame_cnt + 16'd1;
      dcmi_vsync  <= (state == CAPTURE) && in_v;
      dcmi_hsync  <= line_vld;
      dcmi_data   <= line_vld ? {4'b0000, pix_src} : 8'h00;
      dcmi_pix_en <= (state != IDLE);
    end
  end

endmodule

// File: tb/tb_zx_frame_gate.sv
// Randomised bench for zx_frame_gate: a frame-level behavioural model checked every cycle, plus literal scenario checks.
module tb_zx_frame_gate;

  localparam int CW   = 10;
  localparam int HS0  = 2;
  localparam int HL0  = 4;
  localparam int VS0  = 1;
  localparam int VL0  = 2;
  localparam int MAXC = (1 << CW) - 1;

  logic        clk;
  logic        reset;
  logic [3:0]  zx_rgbi;
  logic        zx_hs, zx_vs;
  logic        cfg_enable, cfg_single, cfg_pattern, arm;
  logic [3:0]  cfg_skip;
  logic [7:0]  dcmi_data;
  logic        dcmi_vsync, dcmi_hsync, dcmi_pix_en, busy, frame_done;
  logic [15:0] frame_cnt;

  zx_frame_gate #(.CNT_W(CW), .H_START(HS0), .H_LEN(HL0), .V_START(VS0), .V_LEN(VL0)) dut (
    .ZX_PIX_CLK(clk), .reset(reset), .zx_rgbi(zx_rgbi), .zx_hs(zx_hs), .zx_vs(zx_vs),
    .cfg_enable(cfg_enable), .cfg_single(cfg_single), .cfg_skip(cfg_skip),
    .cfg_pattern(cfg_pattern), .arm(arm), .dcmi_data(dcmi_data), .dcmi_vsync(dcmi_vsync),
    .dcmi_hsync(dcmi_hsync), .dcmi_pix_en(dcmi_pix_en), .busy(busy),
    .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_on = 0;
  bit rand_pix = 0;
  int hs_seen, a_seen, done_seen;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Behavioural model: sync positions as plain integers, capture policy at frame granularity.
  bit          m_hs_prev, m_vs_prev, m_active, m_capturing;
  int          m_hpos, m_vpos, m_skip_left;
  logic [15:0] m_cnt;
  logic [7:0]  e_data;
  logic        e_vsync, e_hsync, e_pix_en, e_busy, e_done;
  bit          hr, vr, win_v, win_h;
  logic [3:0]  pix;

  always @(posedge clk) begin
    if (!reset) begin
      m_hs_prev = 0; m_vs_prev = 0; m_active = 0; m_capturing = 0;
      m_hpos = 0; m_vpos = 0; m_skip_left = 0; m_cnt = 16'd0;
      e_data = 8'h00; e_vsync = 0; e_hsync = 0; e_pix_en = 0; e_busy = 0; e_done = 0;
    end else begin
      hr = zx_hs && !m_hs_prev;
      vr = zx_vs && !m_vs_prev;
      win_v = (m_vpos >= VS0) && (m_vpos < VS0 + VL0);
      win_h = (m_hpos >= HS0) && (m_hpos < HS0 + HL0);
      e_vsync = m_capturing && win_v;
      e_hsync = e_vsync && win_h;
`ifdef ZX_FRAME_GATE_PATTERN_EN
      pix = cfg_pattern ? 4'(m_hpos >> 3) : zx_rgbi;
`else
      pix = zx_rgbi;
`endif
      e_data   = e_hsync ? {4'h0, pix} : 8'h00;
      e_pix_en = m_active;
      e_done   = 0;
      if (!m_active) begin
        if (cfg_enable && (!cfg_single || arm)) begin
          m_active = 1; m_capturing = 0; m_skip_left = 0;
        end
      end else if (m_capturing) begin
        if (vr) begin
          e_done = 1;
          if (cfg_single || !cfg_enable) begin
            m_active = 0; m_capturing = 0;
          end else if (cfg_skip != 0) begin
            m_capturing = 0; m_skip_left = cfg_skip;
          end
        end
      end else if (!cfg_enable) begin
        m_active = 0;
      end else if (vr) begin
        if (m_skip_left <= 1) begin
          m_capturing = 1; m_skip_left = 0;
        end else begin
          m_skip_left--;
        end
      end
      if (e_done) m_cnt = m_cnt + 16'd1;
      e_busy = m_active;
      m_hpos = hr ? 0 : ((m_hpos < MAXC) ? m_hpos + 1 : MAXC);
      if (vr) m_vpos = 0;
      else if (hr) m_vpos = (m_vpos < MAXC) ? m_vpos + 1 : MAXC;
      m_hs_prev = zx_hs;
      m_vs_prev = zx_vs;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("dcmi_data", 16'(dcmi_data), 16'(e_data));
      chk("dcmi_vsync", 16'(dcmi_vsync), 16'(e_vsync));
      chk("dcmi_hsync", 16'(dcmi_hsync), 16'(e_hsync));
      chk("dcmi_pix_en", 16'(dcmi_pix_en), 16'(e_pix_en));
      chk("busy", 16'(busy), 16'(e_busy));
      chk("frame_done", 16'(frame_done), 16'(e_done));
      chk("frame_cnt", frame_cnt, m_cnt);
      if (dcmi_hsync === 1'b1) begin
        hs_seen++;
        if (dcmi_data === 8'h0A) a_seen++;
      end
      if (frame_done === 1'b1) done_seen++;
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      zx_hs = 0; zx_vs = 0; arm = 0; reset = 1;
      if (rand_pix) zx_rgbi = 4'($urandom);
    end
  endtask

  // One frame: 4 lines of 10 clocks, hs on the first clock of each line, vs on the first two.
  task automatic run_frame(input int drop_at, input int arm_at, input int rst_at);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == rst_at) begin
        chk("pre_reset_vsync", 16'(dcmi_vsync), 16'd1);
        chk("pre_reset_hsync", 16'(dcmi_hsync), 16'd1);
      end
      if (rst_at >= 0 && c == rst_at + 1) begin
        chk("rst_frame_cnt", frame_cnt, 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_vsync", 16'(dcmi_vsync), 16'd0);
        chk("rst_hsync", 16'(dcmi_hsync), 16'd0);
        chk("rst_data", 16'(dcmi_data), 16'd0);
        chk("rst_pix_en", 16'(dcmi_pix_en), 16'd0);
        chk("rst_done", 16'(frame_done), 16'd0);
      end
      zx_hs = (c % 10 == 0);
      zx_vs = (c < 2);
      arm   = (c == arm_at);
      reset = (c == rst_at) ? 1'b0 : 1'b1;
      if (c == drop_at) cfg_enable = 0;
      if (rand_pix) zx_rgbi = 4'($urandom);
    end
  endtask

  initial begin
    reset = 0; zx_rgbi = 4'h0; zx_hs = 0; zx_vs = 0;
    cfg_enable = 0; cfg_single = 0; cfg_skip = 4'd0; cfg_pattern = 0; arm = 0;
    repeat (3) @(negedge clk);
    chk_on = 1;
    chk("reset_frame_cnt", frame_cnt, 16'd0);
    chk("reset_busy", 16'(busy), 16'd0);
    chk("reset_outputs", {8'h00, dcmi_data}, 16'd0);

    // Continuous, back-to-back frames with a fixed pixel value
    cfg_enable = 1; zx_rgbi = 4'hA;
    hs_seen = 0; a_seen = 0; done_seen = 0;
    idle(3);
    for (int f = 0; f < 4; f++) run_frame(-1, -1, -1);
    chk("cont_frame_cnt", frame_cnt, 16'd3);
    chk("cont_hsync_cycles", 16'(hs_seen), 16'd32);
    chk("cont_data_0A", 16'(a_seen), 16'd32);
    chk("cont_done_pulses", 16'(done_seen), 16'd3);

    // Enable dropped mid-frame: frame completes, then idle
    run_frame(20, -1, -1);
    run_frame(-1, -1, -1);
    chk("drop_frame_cnt", frame_cnt, 16'd5);
    chk("drop_busy", 16'(busy), 16'd0);
    chk("drop_pix_en", 16'(dcmi_pix_en), 16'd0);
    chk("drop_done_pulses", 16'(done_seen), 16'd5);

    // Reset pulse in the middle of a captured line
    cfg_enable = 1;
    idle(2);
    run_frame(-1, -1, -1);
    run_frame(-1, -1, 15);
    cfg_enable = 0;
    idle(3);

    // Single-shot
    rand_pix = 1; cfg_single = 1; cfg_enable = 1; done_seen = 0;
    idle(2);
    run_frame(-1, -1, -1);
    run_frame(-1, -1, -1);
    chk("single_noarm_busy", 16'(busy), 16'd0);
    chk("single_noarm_cnt", frame_cnt, 16'd0);
    run_frame(-1, 15, -1);
    run_frame(-1, 15, -1);
    run_frame(-1, -1, -1);
    run_frame(-1, -1, -1);
    chk("single_cnt", frame_cnt, 16'd1);
    chk("single_busy", 16'(busy), 16'd0);
    chk("single_done_pulses", 16'(done_seen), 16'd1);

    // Decimation: skip 2 frames between captures
    cfg_single = 0; cfg_skip = 4'd2; cfg_pattern = 1;
    hs_seen = 0; done_seen = 0;
    idle(2);
    for (int f = 0; f < 9; f++) run_frame(-1, -1, -1);
    chk("skip_frame_cnt", frame_cnt, 16'd4);
    chk("skip_done_pulses", 16'(done_seen), 16'd3);
    chk("skip_hsync_cycles", 16'(hs_seen), 16'd24);
    cfg_enable = 0;
    idle(2);
    chk("skip_off_busy", 16'(busy), 16'd0);

    // Randomised configuration traffic
    for (int f = 0; f < 24; f++) begin
      cfg_enable  = ($urandom_range(0, 3) != 0);
      cfg_single  = 1'($urandom);
      cfg_skip    = 4'($urandom_range(0, 3));
      cfg_pattern = 1'($urandom);
      run_frame(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 39)) : -1,
                int'($urandom_range(0, 45)), -1);
    end

    chk_on = 0;
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/zx_frame_gate.md
Name: zx_frame_gate

Overview:
- Frame-capture sequencer between the ZX RGBI pixel stream and the DCMI port.
- Aligns capture to ZX frame boundaries and crops a programmable active window. Generates DCMI frame-valid and line-valid strobes and a pixel-clock gate.
- Supports single-shot (armed) and continuous capture, with frame decimation.
- Configured by the SPI control-register logic through level inputs already synchronous to ZX_PIX_CLK.

Parameters:
CNT_W, 10, width of the horizontal and vertical counters
H_START, 64, first captured pixel index after an HS rising edge
H_LEN, 256, captured pixels per line
V_START, 48, first captured line index after a VS rising edge
V_LEN, 192, captured lines per frame

Ports:
ZX_PIX_CLK  in  1  pixel clock; all logic on rising edge
reset  in  1  synchronous, active-low
zx_rgbi  in  4  {I,B,G,R} pixel sample
zx_hs  in  1  ZX horizontal sync, active-high
zx_vs  in  1  ZX vertical sync, active-high
cfg_enable  in  1  capture engine enable
cfg_single  in  1  1 = single-shot (needs arm), 0 = continuous
cfg_skip  in  4  frames skipped between captured frames (continuous mode)
cfg_pattern  in  1  test-pattern select (used only with ZX_FRAME_GATE_PATTERN_EN)
arm  in  1  one-cycle request for a single-shot capture
dcmi_data  out  8  {4'b0, I,B,G,R}; zero outside the window
dcmi_vsync  out  1  frame-valid, high across captured window lines
dcmi_hsync  out  1  line-valid, high for in-window pixels
dcmi_pix_en  out  1  gate for DCMI_PIXCLK
busy  out  1  state != IDLE
frame_done  out  1  one-cycle pulse at the end of each captured frame
frame_cnt  out  16  count of captured frames, wraps at 0xFFFF->0

Behaviour:
- Reset (reset==0 at a clock edge) has priority over everything, including an operation in progress.
  - All outputs go to 0, state goes to IDLE, counters and skip counter clear.
- Edge detect:
  - hs_d and vs_d are registered copies of the syncs.
  - hs_rise = zx_hs & ~hs_d; vs_rise = zx_vs & ~vs_d.
- h_cnt:
  - Goes to 0 on hs_rise; otherwise increments.
  - Saturates at 2^CNT_W-1.
- v_cnt:
  - Goes to 0 on vs_rise; otherwise increments on hs_rise.
  - Saturates at 2^CNT_W-1.
  - vs_rise wins over a simultaneous hs_rise.
- Window:
  - in_v = V_START <= v_cnt < V_START+V_LEN.
  - in_h = H_START <= h_cnt < H_START+H_LEN.
  - The window is truncated silently if a sync edge arrives before its end.
- States:
  - IDLE: leave on cfg_enable & (~cfg_single | arm), going to WAIT_VS. arm is ignored in every other state.
  - WAIT_VS: on vs_rise, go to CAPTURE.
  - CAPTURE:
    - Outputs are active.
    - On vs_rise: pulse frame_done and increment frame_cnt. Then:
      - if cfg_single or ~cfg_enable, go to IDLE;
      - else if cfg_skip != 0, load skip_cnt = cfg_skip and go to SKIP;
      - else stay in CAPTURE, back-to-back frames.
  - SKIP:
    - On vs_rise, decrement skip_cnt; at 1->0, go to CAPTURE.
    - If ~cfg_enable, go to IDLE immediately.
  - WAIT_VS on ~cfg_enable also goes to IDLE immediately.
  - Dropping cfg_enable in CAPTURE does not abort: the current frame completes first.
- Outputs are all registered, 1-cycle latency from the sampled inputs.
  - dcmi_vsync = CAPTURE & in_v.
  - dcmi_hsync = CAPTURE & in_v & in_h.
  - dcmi_data = dcmi_hsync-term ? {4'b0, zx_rgbi} : 8'h00.
  - dcmi_pix_en = (state != IDLE).
- frame_done and the frame_cnt increment occur in the same cycle.
- Config changes are sampled only at state transitions, except cfg_enable as described above.

Optional Feature:
- Macro: ZX_FRAME_GATE_PATTERN_EN.
- Defined:
  - When cfg_pattern==1, in-window data is replaced by colour bars: dcmi_data = {4'b0, h_cnt[6:3]}.
  - Sync, window and state behaviour are unchanged.
- Undefined:
  - cfg_pattern is ignored; the port remains and is left unconnected internally.

Test Plan:
- Bench parameters for all scenarios: H_START=2, H_LEN=4, V_START=1, V_LEN=2. Line = 10 clocks, frame = 4 lines.
- Continuous, cfg_skip=0, zx_rgbi=4'hA:
  - After the first vs_rise, each frame gives 2 lines with dcmi_vsync high.
  - Each line has dcmi_hsync high for exactly 4 clocks, each with dcmi_data=8'h0A.
  - frame_done pulses at every subsequent vs_rise; frame_cnt goes 1,2,3.
- Single-shot:
  - cfg_single=1, no arm -> busy stays 0.
  - One arm pulse -> exactly one captured frame, then frame_cnt=1, busy=0.
  - A second arm during CAPTURE is ignored.
- Decimation, cfg_skip=2 over 9 frames -> captured frames 1, 4, 7; frame_cnt=3.
- cfg_enable dropped mid-CAPTURE -> current frame completes, frame_done pulses, then IDLE with dcmi_pix_en=0.
- reset=0 asserted for one cycle mid-window -> next cycle all outputs 0 and state IDLE; frame_cnt=0.
- With ZX_FRAME_GATE_PATTERN_EN defined and cfg_pattern=1 -> in-window dcmi_data follows h_cnt[6:3]; without the macro, the data equals zx_rgbi.
